timer_counter: RTL and testbench

- Counter core of the APB timer; sits directly downstream of the timer's APB register block.
- Consumes the register-derived controls: enable, count direction, clock-divide select, load strobe, load value and interrupt enable.
- Produces the count value, one-cycle overflow/underflow pulses (fed back to the status register as over/under) and a level interrupt request.

---
 rtl/timer_counter_if.sv | 30 +++
 rtl/timer_counter.sv | 84 ++++++++
 tb/tb_timer_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Control and status bundle between the APB timer register block and its counter core.
// Latency: none; plain wires grouped for port readability.
// Backpressure: none; controls are levels/strobes, status is registered by the core.
interface timer_counter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             updown;
  logic [1:0]       clk_s;
  logic             init_cnt;
  logic [CNT_W-1:0] timer_val;
  logic             inter_en;
  logic             irq_clr;
  logic [CNT_W-1:0] cnt;
  logic             over;
  logic             under;
  logic             irq;

  // Register block side: drives controls, observes count and status.
  modport master (
    output en, updown, clk_s, init_cnt, timer_val, inter_en, irq_clr,
    input  cnt, over, under, irq
  );

  // Counter core side.
  modport slave (
    input  en, updown, clk_s, init_cnt, timer_val, inter_en, irq_clr,
    output cnt, over, under, irq
  );
endinterface

// File: rtl/timer_counter.sv
// Prescaled up/down counter with load, wrap pulses and a sticky interrupt request.
// Latency: count steps every 2/4/8/16 enabled edges; over/under/irq registered on the wrap edge.
// Backpressure: none; load overrides counting, en=0 freezes count and clears the prescaler.
module timer_counter #(
  parameter int CNT_W = 8
) (
  input  logic          pclk,
  input  logic          preset,
  timer_counter_if.slave tif
);

  logic [3:0]       pre;
  logic [3:0]       tick_mask;
  logic             tick;
  logic             wrap_up;
  logic             wrap_dn;
  logic             irq_set;
  logic [CNT_W-1:0] cnt_q;
  logic             over_q;
  logic             under_q;
  logic             irq_q;

  // Tick when the prescaler bits selected by clk_s are all ones; wraps are qualified ticks.
  always_comb begin
    tick_mask = 4'b0001;
    case (tif.clk_s)
      2'b00:   tick_mask = 4'b0001;
      2'b01:   tick_mask = 4'b0011;
      2'b10:   tick_mask = 4'b0111;
      default: tick_mask = 4'b1111;
    endcase
    tick    = tif.en & ~tif.init_cnt & (&(pre | ~tick_mask));
    wrap_up = tick & ~tif.updown & (&cnt_q);
    wrap_dn = tick &  tif.updown & (cnt_q == '0);
    irq_set = tif.inter_en & (wrap_up | wrap_dn);
  end

  // Prescaler free-runs while counting; held at zero while disabled or loading.
  always_ff @(posedge pclk) begin
    if (preset)
      pre <= 4'd0;
    else if (!tif.en || tif.init_cnt)
      pre <= 4'd0;
    else
      pre <= pre + 4'd1;
  end

  // Count register: load beats tick, tick beats hold.
  always_ff @(posedge pclk) begin
    if (preset)
      cnt_q <= '0;
    else if (tif.init_cnt)
      cnt_q <= tif.timer_val;
    else if (tick)
      cnt_q <= tif.updown ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
  end

  // Single-cycle wrap pulses, aligned with the edge that wraps the count.
  always_ff @(posedge pclk) begin
    if (preset) begin
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      over_q  <= wrap_up;
      under_q <= wrap_dn;
    end
  end

  // Sticky interrupt: a new wrap with inter_en set wins over a simultaneous clear.
  always_ff @(posedge pclk) begin
    if (preset)
      irq_q <= 1'b0;
    else if (irq_set)
      irq_q <= 1'b1;
    else if (tif.irq_clr)
      irq_q <= 1'b0;
  end

  assign tif.cnt   = cnt_q;
  assign tif.over  = over_q;
  assign tif.under = under_q;
  assign tif.irq   = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a cycle-tagged expectation queue.
// Latency: expectations are tagged with the edge count after which they must hold.
// Backpressure: none; the monitor checks on every falling edge.
module tb_timer_counter;

  logic pclk = 1'b0;
  logic preset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] cnt;
    logic       over;
    logic       under;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  timer_counter_if #(.CNT_W(8)) tif ();

  timer_counter #(.CNT_W(8)) dut (
    .pclk   (pclk),
    .preset (preset),
    .tif    (tif)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose edge has been reached.
  always @(negedge pclk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc != cyc || tif.cnt !== e.cnt || tif.over !== e.over ||
          tif.under !== e.under || tif.irq !== e.irq) begin
        errors++;
        $display("FAIL %s at edge %0d (due %0d): got cnt=%02h over=%b under=%b irq=%b, want cnt=%02h over=%b under=%b irq=%b",
                 e.name, cyc, e.cyc, tif.cnt, tif.over, tif.under, tif.irq,
                 e.cnt, e.over, e.under, e.irq);
      end
    end
  end

  task automatic exp_at(input int dly, input string nm, input logic [7:0] c,
                        input logic o, input logic u, input logic i);
    exp_t x;
    x.cyc = cyc + dly; x.name = nm; x.cnt = c; x.over = o; x.under = u; x.irq = i;
    sb_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  initial begin
    preset       = 1'b1;
    tif.en       = 1'b0;
    tif.updown   = 1'b0;
    tif.clk_s    = 2'b00;
    tif.init_cnt = 1'b0;
    tif.timer_val = 8'h00;
    tif.inter_en = 1'b0;
    tif.irq_clr  = 1'b0;

    // Reset state, then count up /2
    step(1);
    exp_at(1, "reset", 8'h00, 0, 0, 0);
    step(1);
    preset = 1'b0; tif.en = 1'b1;
    exp_at(1, "t1_e1", 8'h00, 0, 0, 0);
    exp_at(2, "t1_e2", 8'h01, 0, 0, 0);
    exp_at(3, "t1_e3", 8'h01, 0, 0, 0);
    exp_at(4, "t1_e4", 8'h02, 0, 0, 0);
    exp_at(6, "t1_e6", 8'h03, 0, 0, 0);
    step(6);

    // Load FE, count up /4 through the overflow, interrupt then clear
    tif.init_cnt = 1'b1; tif.timer_val = 8'hFE; tif.clk_s = 2'b01; tif.inter_en = 1'b1;
    exp_at(1, "t2_load", 8'hFE, 0, 0, 0);
    step(1);
    tif.init_cnt = 1'b0;
    exp_at(3, "t2_e3", 8'hFE, 0, 0, 0);
    exp_at(4, "t2_e4", 8'hFF, 0, 0, 0);
    exp_at(7, "t2_e7", 8'hFF, 0, 0, 0);
    exp_at(8, "t2_wrap", 8'h00, 1, 0, 1);
    exp_at(9, "t2_after", 8'h00, 0, 0, 1);
    step(9);
    tif.irq_clr = 1'b1;
    exp_at(1, "t2_clr", 8'h00, 0, 0, 0);
    step(1);
    tif.irq_clr = 1'b0;
    exp_at(1, "t2_clr_hold", 8'h00, 0, 0, 0);
    step(1);

    // Load 01, count down /16 through the underflow with interrupts disabled
    tif.init_cnt = 1'b1; tif.timer_val = 8'h01; tif.updown = 1'b1;
    tif.clk_s = 2'b11; tif.inter_en = 1'b0;
    exp_at(1, "t3_load", 8'h01, 0, 0, 0);
    step(1);
    tif.init_cnt = 1'b0;
    exp_at(15, "t3_e15", 8'h01, 0, 0, 0);
    exp_at(16, "t3_e16", 8'h00, 0, 0, 0);
    exp_at(31, "t3_e31", 8'h00, 0, 0, 0);
    exp_at(32, "t3_wrap", 8'hFF, 0, 1, 0);
    exp_at(33, "t3_after", 8'hFF, 0, 0, 0);
    step(33);

    // Count up /8, pause en for 10 cycles, prescaler restarts from zero
    tif.init_cnt = 1'b1; tif.timer_val = 8'h00; tif.updown = 1'b0; tif.clk_s = 2'b10;
    exp_at(1, "t4_load", 8'h00, 0, 0, 0);
    step(1);
    tif.init_cnt = 1'b0;
    exp_at(7, "t4_e7", 8'h00, 0, 0, 0);
    exp_at(8, "t4_e8", 8'h01, 0, 0, 0);
    step(10);
    tif.en = 1'b0;
    exp_at(1, "t4_gap1", 8'h01, 0, 0, 0);
    exp_at(10, "t4_gap10", 8'h01, 0, 0, 0);
    step(10);
    tif.en = 1'b1;
    exp_at(7, "t4_re7", 8'h01, 0, 0, 0);
    exp_at(8, "t4_re8", 8'h02, 0, 0, 0);
    exp_at(9, "t4_re9", 8'h02, 0, 0, 0);
    step(9);

    // Clear and overflow on the same edge: set wins; then reset mid-count at 5A
    tif.init_cnt = 1'b1; tif.timer_val = 8'hFF; tif.clk_s = 2'b00; tif.inter_en = 1'b1;
    exp_at(1, "t5_load", 8'hFF, 0, 0, 0);
    step(1);
    tif.init_cnt = 1'b0;
    exp_at(1, "t5_e1", 8'hFF, 0, 0, 0);
    step(1);
    tif.irq_clr = 1'b1;
    exp_at(1, "t5_setwins", 8'h00, 1, 0, 1);
    step(1);
    tif.irq_clr = 1'b0;
    tif.init_cnt = 1'b1; tif.timer_val = 8'h5A;
    exp_at(1, "t5_load5a", 8'h5A, 0, 0, 1);
    step(1);
    tif.init_cnt = 1'b0;
    exp_at(1, "t5_run", 8'h5A, 0, 0, 1);
    step(1);
    preset = 1'b1;
    exp_at(1, "t5_preset", 8'h00, 0, 0, 0);
    step(1);
    preset = 1'b0;

    // Held load tracks timer_val one edge later, no pulses
    tif.init_cnt = 1'b1; tif.en = 1'b1; tif.updown = 1'b0; tif.inter_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tif.timer_val = (i < 10) ? 8'd10 : 8'd20;
      exp_at(1, "t6_track", (i < 10) ? 8'd10 : 8'd20, 0, 0, 0);
      step(1);
    end
    tif.init_cnt = 1'b0;
    exp_at(1, "t6_rel1", 8'd20, 0, 0, 0);
    exp_at(2, "t6_rel2", 8'd21, 0, 0, 0);
    step(2);

    // Drain any outstanding expectations within a bounded window
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) step(1);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
